// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a shared sram-like memory port: fetch vs data,
// with grant lock until accept, fetch starvation guard and in-order response routing.
module mem_port_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_cache,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_cache,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [2:0]  data_size,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic        mem_req,
  output logic        mem_cache,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_size,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,

  output logic        resp_err
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STK_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STARVE_LIMIT);

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  src_e             fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             lock_vld_q, lock_vld_d;
  src_e             lock_src_q, lock_src_d;
  logic [STK_W-1:0] streak_q, streak_d;
  logic             resp_err_q, resp_err_d;

  logic grant_vld;
  src_e grant_src;
  logic push, pop;
  src_e head;

  // Grant is derived purely from registered state plus current requests.
  always_comb begin
    grant_vld = 1'b0;
    grant_src = SRC_DATA;
    if (lock_vld_q) begin
      grant_vld = 1'b1;
      grant_src = lock_src_q;
    end else if (count_q == FULL_CNT) begin
      grant_vld = 1'b0;
    end else if (inst_req && data_req) begin
      grant_vld = 1'b1;
      grant_src = (streak_q == STK_MAX) ? SRC_INST : SRC_DATA;
    end else if (data_req) begin
      grant_vld = 1'b1;
      grant_src = SRC_DATA;
    end else if (inst_req) begin
      grant_vld = 1'b1;
      grant_src = SRC_INST;
    end
  end

  always_comb begin
    mem_req = resetn && grant_vld &&
              ((grant_src == SRC_INST) ? inst_req : data_req);
    mem_cache = data_cache;
    mem_wr    = data_wr;
    mem_wstrb = data_wstrb;
    mem_addr  = data_addr;
    mem_size  = data_size;
    mem_wdata = data_wdata;
    if (grant_src == SRC_INST) begin
      mem_cache = inst_cache;
      mem_wr    = 1'b0;
      mem_wstrb = '0;
      mem_addr  = inst_addr;
      mem_size  = 3'd2;
      mem_wdata = '0;
    end
  end

  assign push = mem_req && mem_addr_ok;
  assign pop  = mem_data_ok && (count_q != '0);
  assign head = fifo_q[rd_ptr_q];

  assign inst_addr_ok = push && (grant_src == SRC_INST);
  assign data_addr_ok = push && (grant_src == SRC_DATA);
  assign inst_data_ok = pop && (head == SRC_INST);
  assign data_data_ok = pop && (head == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign resp_err     = resp_err_q;

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) count_d = count_q + CNT_W'(1);
    if (!push && pop) count_d = count_q - CNT_W'(1);
    // A pending, unaccepted request pins the grant; a dropped req releases it.
    lock_vld_d = mem_req && !mem_addr_ok;
    lock_src_d = grant_src;
    streak_d   = streak_q;
    if (push && (grant_src == SRC_DATA) && inst_req) begin
      if (streak_q != STK_MAX) streak_d = streak_q + STK_W'(1);
    end else if ((push && (grant_src == SRC_INST)) || !inst_req) begin
      streak_d = '0;
    end
    resp_err_d = resp_err_q || (mem_data_ok && (count_q == '0));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      lock_vld_q <= 1'b0;
      lock_src_q <= SRC_INST;
      streak_q   <= '0;
      resp_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      lock_vld_q <= lock_vld_d;
      lock_src_q <= lock_src_d;
      streak_q   <= streak_d;
      resp_err_q <= resp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= grant_src;
  end

endmodule
